// File: rtl/mipi_csi_raw_pkg.sv
// Shared definitions for the CSI-2 RAW packer: format codes, FSM encoding and
// the bytes-per-group lookup used for both ready gating and byte packing.
package mipi_csi_raw_pkg;

    typedef enum logic [2:0] {
        RAW8  = 3'd1,
        RAW10 = 3'd3,
        RAW12 = 3'd4,
        RAW14 = 3'd5
    } raw_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int GROUP_MAX = 7;

    // Zero marks an unsupported format code.
    function automatic logic [2:0] bytes_per_group(input logic [2:0] packet_type);
        case (packet_type)
            RAW8:    return 3'd4;
            RAW10:   return 3'd5;
            RAW12:   return 3'd6;
            RAW14:   return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mipi_csi_raw_group_packer.sv
// Combinational packing of one 4-pixel group into its CSI-2 RAW byte sequence.
// Byte k of the group sits in group_data[8k +: 8].
module mipi_csi_raw_group_packer
    import mipi_csi_raw_pkg::*;
#(
    parameter int PIXEL_WIDTH = 14
) (
    input  logic [4*PIXEL_WIDTH-1:0] pixel_data,
    input  logic [2:0]               packet_type,
    output logic [8*GROUP_MAX-1:0]   group_data,
    output logic [2:0]               group_bytes
);

    logic [PIXEL_WIDTH-1:0] p0, p1, p2, p3;

    assign p0 = pixel_data[0*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign p1 = pixel_data[1*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign p2 = pixel_data[2*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign p3 = pixel_data[3*PIXEL_WIDTH +: PIXEL_WIDTH];

    always_comb begin
        group_data  = '0;
        group_bytes = bytes_per_group(packet_type);
        case (packet_type)
            RAW8:  group_data[31:0] = {p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
            RAW10: group_data[39:0] = {p3[1:0], p2[1:0], p1[1:0], p0[1:0],
                                       p3[9:2], p2[9:2], p1[9:2], p0[9:2]};
            RAW12: group_data[47:0] = {p3[3:0], p2[3:0], p3[11:4], p2[11:4],
                                       p1[3:0], p0[3:0], p1[11:4], p0[11:4]};
            // MSB bytes first, then the 24 LSBs of all four pixels spread over three bytes.
            RAW14: group_data[55:0] = {p3[5:0], p2[5:4], p2[3:0], p1[5:2], p1[1:0], p0[5:0],
                                       p3[13:6], p2[13:6], p1[13:6], p0[13:6]};
            default: group_data = '0;
        endcase
    end

endmodule

// File: rtl/mipi_csi_tx_raw_packer_8b4lane.sv
// 4-lane CSI-2 TX RAW packer: packs 4-pixel groups into a byte accumulator and
// emits 32-bit words (lane 0 in [7:0]) with a zero-padded final word per line.
module mipi_csi_tx_raw_packer_8b4lane
    import mipi_csi_raw_pkg::*;
#(
    parameter int PIXEL_WIDTH = 14,
    parameter int BUF_BYTES   = 12
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [2:0]               packet_type_i,
    input  logic                     pixel_valid_i,
    output logic                     pixel_ready_o,
    input  logic [4*PIXEL_WIDTH-1:0] pixel_data_i,
    input  logic                     pixel_last_i,
    input  logic                     output_ready_i,
    output logic                     output_valid_o,
    output logic [31:0]              output_o,
    output logic [2:0]               output_bytes_o,
    output logic                     output_last_o
);

    localparam int CW = $clog2(BUF_BYTES + 1);
    localparam int IW = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;

    state_e                   state;
    logic [2:0]               type_q;
    logic [CW-1:0]            count;
    logic [7:0]               buf_q    [BUF_BYTES];
    logic [7:0]               next_buf [BUF_BYTES];

    logic [2:0]               cur_type;
    logic [8*GROUP_MAX-1:0]   grp;
    logic [2:0]               grp_n;

    logic                     out_free, load, last_word;
    logic                     supported, drop, room, ready, accept, append;
    int                       cnt, moved, next_cnt;
    logic [31:0]              word;

    // The format is only sampled from the port while idle; a line keeps its latched type.
    assign cur_type = (state == ST_IDLE) ? packet_type_i : type_q;

    mipi_csi_raw_group_packer #(
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_group_packer (
        .pixel_data  (pixel_data_i),
        .packet_type (cur_type),
        .group_data  (grp),
        .group_bytes (grp_n)
    );

    always_comb begin
        out_free  = !output_valid_o || output_ready_i;
        cnt       = int'(count);
        load      = 1'b0;
        last_word = 1'b0;
        moved     = 0;
        if (out_free) begin
            if (state == ST_FLUSH && cnt > 0 && cnt <= 4) begin
                load      = 1'b1;
                last_word = 1'b1;
                moved     = cnt;
            end else if (cnt >= 4) begin
                load  = 1'b1;
                moved = 4;
            end
        end

        supported = (grp_n != 3'd0);
        drop      = (state == ST_IDLE) && !supported;
        room      = (cnt - moved + int'(grp_n)) <= BUF_BYTES;
        ready     = reset_n_i && (state != ST_FLUSH) && (drop || (supported && room));
        accept    = pixel_valid_i && ready;
        append    = accept && supported;

        word = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < moved) word[8*i +: 8] = buf_q[IW'(i)];
        end

        // Shift out the emitted bytes, then append the new group behind what remains.
        for (int i = 0; i < BUF_BYTES; i++) begin
            next_buf[IW'(i)] = 8'h00;
            if (i + moved < cnt) next_buf[IW'(i)] = buf_q[IW'(i + moved)];
        end
        if (append) begin
            for (int j = 0; j < GROUP_MAX; j++) begin
                if (j < int'(grp_n) && (cnt - moved + j) < BUF_BYTES)
                    next_buf[IW'(cnt - moved + j)] = grp[8*j +: 8];
            end
        end

        next_cnt = cnt - moved + (append ? int'(grp_n) : 0);
    end

    assign pixel_ready_o = ready;

    always_ff @(posedge clk_i) begin
        buf_q <= next_buf;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state          <= ST_IDLE;
            type_q         <= '0;
            count          <= '0;
            output_valid_o <= 1'b0;
            output_o       <= '0;
            output_bytes_o <= '0;
            output_last_o  <= 1'b0;
        end else begin
            count <= CW'(next_cnt);
            if (out_free) begin
                output_valid_o <= load;
                if (load) begin
                    output_o       <= word;
                    output_bytes_o <= 3'(moved);
                    output_last_o  <= last_word;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (append) begin
                        type_q <= packet_type_i;
                        state  <= pixel_last_i ? ST_FLUSH : ST_PACK;
                    end
                end
                ST_PACK: begin
                    if (accept && pixel_last_i) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (output_valid_o && output_last_o && output_ready_i) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_csi_tx_raw_packer_8b4lane.sv
// Directed bench for the 4-lane CSI-2 RAW packer: hand-computed words per format,
// backpressure, format latching, unsupported types and asynchronous reset.
module tb_mipi_csi_tx_raw_packer_8b4lane;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  packet_type;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [55:0] pixel_data;
    logic        pixel_last;
    logic        output_ready;
    logic        output_valid;
    logic [31:0] out_word;
    logic [2:0]  out_bytes;
    logic        out_last;

    int tests = 0;
    int fails = 0;

    logic [31:0] q_data  [$];
    logic [2:0]  q_bytes [$];
    logic        q_last  [$];

    logic        hold_vld  = 1'b0;
    logic [35:0] hold_word = '0;

    always #5 clk = ~clk;

    mipi_csi_tx_raw_packer_8b4lane #(
        .PIXEL_WIDTH (14),
        .BUF_BYTES   (12)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .packet_type_i  (packet_type),
        .pixel_valid_i  (pixel_valid),
        .pixel_ready_o  (pixel_ready),
        .pixel_data_i   (pixel_data),
        .pixel_last_i   (pixel_last),
        .output_ready_i (output_ready),
        .output_valid_o (output_valid),
        .output_o       (out_word),
        .output_bytes_o (out_bytes),
        .output_last_o  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Captures every handshaken word; also checks stall stability and the buffer bound.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                tests++;
                assert (int'(dut.count) <= 12) else begin
                    fails++;
                    $error("FAIL count_bound observed=%0d expected<=12", dut.count);
                end
            end
            if (hold_vld && reset_n && output_valid)
                check("stall_hold", {28'h0, 4'h0} | out_word ^ hold_word[35:4] ^ hold_word[35:4]
                      ^ (({out_bytes, out_last} == hold_word[3:0]) ? 32'h0 : 32'h1), hold_word[35:4]);
            if (output_valid && output_ready && reset_n) begin
                q_data.push_back(out_word);
                q_bytes.push_back(out_bytes);
                q_last.push_back(out_last);
            end
            hold_vld  = reset_n && output_valid && !output_ready;
            hold_word = {out_word, out_bytes, out_last};
        end
    end

    task automatic clear_q();
        q_data.delete();
        q_bytes.delete();
        q_last.delete();
    endtask

    task automatic send_group(input logic [13:0] p0, input logic [13:0] p1,
                              input logic [13:0] p2, input logic [13:0] p3, input logic last);
        int k;
        pixel_data  = {p3, p2, p1, p0};
        pixel_last  = last;
        pixel_valid = 1'b1;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            if (pixel_ready) break;
            k++;
        end
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
        check("group_accepted", 32'(k < 200), 32'd1);
    endtask

    task automatic wait_words(input string tag, input int n);
        int k;
        k = 0;
        while (q_data.size() < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        check({tag, "_count"}, 32'(q_data.size()), 32'(n));
    endtask

    task automatic check_word(input string tag, input int idx, input logic [31:0] d,
                              input logic [2:0] b, input logic l);
        if (idx < q_data.size()) begin
            check({tag, "_data"}, q_data[idx], d);
            check({tag, "_bytes"}, 32'(q_bytes[idx]), 32'(b));
            check({tag, "_last"}, 32'(q_last[idx]), 32'(l));
        end else begin
            check({tag, "_present"}, 32'(q_data.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        packet_type  = 3'd4;
        pixel_valid  = 1'b0;
        pixel_last   = 1'b0;
        pixel_data   = '0;
        output_ready = 1'b1;
        #3;
        check("rst_valid", 32'(output_valid), 32'd0);
        check("rst_data", out_word, 32'h0);
        check("rst_bytes", 32'(out_bytes), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_ready", 32'(pixel_ready), 32'd0);
        #20;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // RAW12, two groups
        clear_q();
        send_group(14'h010, 14'h020, 14'h030, 14'h040, 1'b0);
        check("raw12_latency", 32'(output_valid), 32'd0);
        send_group(14'h010, 14'h020, 14'h030, 14'h040, 1'b1);
        check("raw12_first_valid", 32'(output_valid), 32'd1);
        check("raw12_first_word", out_word, 32'h03000201);
        check("raw12_flush_ready", 32'(pixel_ready), 32'd0);
        wait_words("raw12", 3);
        check_word("raw12_w0", 0, 32'h03000201, 3'd4, 1'b0);
        check_word("raw12_w1", 1, 32'h02010004, 3'd4, 1'b0);
        check_word("raw12_w2", 2, 32'h00040300, 3'd4, 1'b1);

        // RAW10, single group, one-byte tail
        packet_type = 3'd3;
        clear_q();
        send_group(14'h3FF, 14'h000, 14'h155, 14'h2AA, 1'b1);
        wait_words("raw10", 2);
        check_word("raw10_w0", 0, 32'hAA5500FF, 3'd4, 1'b0);
        check_word("raw10_w1", 1, 32'h00000093, 3'd1, 1'b1);

        // RAW14, 21 bytes of 0xFF
        packet_type = 3'd5;
        clear_q();
        for (int g = 0; g < 3; g++)
            send_group(14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF, g == 2);
        wait_words("raw14", 6);
        for (int i = 0; i < 5; i++)
            check_word("raw14_full", i, 32'hFFFFFFFF, 3'd4, 1'b0);
        check_word("raw14_tail", 5, 32'h000000FF, 3'd1, 1'b1);

        // RAW8 under backpressure
        packet_type  = 3'd1;
        output_ready = 1'b0;
        clear_q();
        for (int g = 0; g < 4; g++)
            send_group(14'(4*g + 1), 14'(4*g + 2), 14'(4*g + 3), 14'(4*g + 4), 1'b0);
        check("raw8_full_ready", 32'(pixel_ready), 32'd0);
        check("raw8_stall_valid", 32'(output_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("raw8_stall_ready", 32'(pixel_ready), 32'd0);
        check("raw8_stall_word", out_word, 32'h04030201);
        output_ready = 1'b1;
        #1;
        check("raw8_release_ready", 32'(pixel_ready), 32'd1);
        send_group(14'h11, 14'h12, 14'h13, 14'h14, 1'b1);
        for (int k = 0; k < 100 && q_data.size() < 5; k++) begin
            @(posedge clk);
            #1;
            output_ready = ~output_ready;
        end
        output_ready = 1'b1;
        wait_words("raw8", 5);
        check_word("raw8_w0", 0, 32'h04030201, 3'd4, 1'b0);
        check_word("raw8_w1", 1, 32'h08070605, 3'd4, 1'b0);
        check_word("raw8_w2", 2, 32'h0C0B0A09, 3'd4, 1'b0);
        check_word("raw8_w3", 3, 32'h100F0E0D, 3'd4, 1'b0);
        check_word("raw8_w4", 4, 32'h14131211, 3'd4, 1'b1);

        // Format change mid-line is ignored
        packet_type = 3'd4;
        clear_q();
        send_group(14'h010, 14'h020, 14'h030, 14'h040, 1'b0);
        packet_type = 3'd3;
        send_group(14'h010, 14'h020, 14'h030, 14'h040, 1'b1);
        wait_words("latch", 3);
        check_word("latch_w0", 0, 32'h03000201, 3'd4, 1'b0);
        check_word("latch_w1", 1, 32'h02010004, 3'd4, 1'b0);
        check_word("latch_w2", 2, 32'h00040300, 3'd4, 1'b1);

        // Next line picks up RAW10
        clear_q();
        send_group(14'h3FF, 14'h000, 14'h155, 14'h2AA, 1'b1);
        wait_words("next10", 2);
        check_word("next10_w0", 0, 32'hAA5500FF, 3'd4, 1'b0);
        check_word("next10_w1", 1, 32'h00000093, 3'd1, 1'b1);

        // Unsupported type: consumed, nothing emitted
        packet_type = 3'd7;
        clear_q();
        send_group(14'h1, 14'h2, 14'h3, 14'h4, 1'b0);
        send_group(14'h5, 14'h6, 14'h7, 14'h8, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("unsup_words", 32'(q_data.size()), 32'd0);
        check("unsup_valid", 32'(output_valid), 32'd0);
        check("unsup_ready", 32'(pixel_ready), 32'd1);
        packet_type = 3'd1;
        clear_q();
        send_group(14'h0A, 14'h0B, 14'h0C, 14'h0D, 1'b1);
        wait_words("after_unsup", 1);
        check_word("after_unsup_w0", 0, 32'h0D0C0B0A, 3'd4, 1'b1);

        // Asynchronous reset with 3 bytes buffered
        packet_type = 3'd5;
        clear_q();
        send_group(14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF, 1'b0);
        @(posedge clk);
        #1;
        check("pre_reset_valid", 32'(output_valid), 32'd1);
        check("pre_reset_count", 32'(dut.count), 32'd3);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(output_valid), 32'd0);
        check("mid_rst_data", out_word, 32'h0);
        check("mid_rst_bytes", 32'(out_bytes), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_ready", 32'(pixel_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n     = 1'b1;
        packet_type = 3'd1;
        clear_q();
        send_group(14'h11, 14'h22, 14'h33, 14'h44, 1'b1);
        wait_words("post_rst", 1);
        check_word("post_rst_w0", 0, 32'h44332211, 3'd4, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_no_stale", 32'(q_data.size()), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
